// File: rtl/pipeline_pkg.sv
// Shared pipeline types: result-source encodings and the packed E-stage control bundle.
package pipeline_pkg;
  localparam int ALUCTRL_W = 4;
  localparam int REGA_W    = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_e;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic [1:0]           result_src;
    logic [ALUCTRL_W-1:0] alu_control;
  } e_ctrl_t;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: a valid load in E whose nonzero destination feeds either D source.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic              valid_e,
  input  logic [1:0]        result_src_e,
  input  logic [REGA_W-1:0] rd_e,
  input  logic [REGA_W-1:0] rs1_d,
  input  logic [REGA_W-1:0] rs2_d,
  output logic              lw_stall
);
  assign lw_stall = valid_e && (result_src_e == RES_LOAD) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
endmodule

// File: rtl/decode_execute_stage.sv
// D->E pipeline register with load-use stall, flush bubble and memory-busy hold.
module decode_execute_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 MemBusyM,
  input  logic [REGA_W-1:0]    Rs1D,
  input  logic [REGA_W-1:0]    Rs2D,
  input  logic [REGA_W-1:0]    RdD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [1:0]           ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  output logic [REGA_W-1:0]    Rs1E,
  output logic [REGA_W-1:0]    Rs2E,
  output logic [REGA_W-1:0]    RdE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ValidE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD
);
  e_ctrl_t ctrl_q, ctrl_d;
  logic    lw_stall;

  load_use_detect u_lud (
    .valid_e      (ctrl_q.valid),
    .result_src_e (ctrl_q.result_src),
    .rd_e         (RdE),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .lw_stall     (lw_stall)
  );

  assign ctrl_d = '{valid: 1'b1, reg_write: RegWriteD, mem_write: MemWriteD,
                    jump: JumpD, branch: BranchD, alu_src: ALUSrcD,
                    result_src: ResultSrcD, alu_control: ALUControlD};

  // Bubbles zero register addresses too, so forwarding never matches a dead slot.
  always_ff @(posedge clk) begin
    if (rst || (!MemBusyM && (flush || lw_stall))) begin
      ctrl_q   <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
    end else if (!MemBusyM) begin
      ctrl_q   <= ctrl_d;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
    end
  end

  assign ValidE      = ctrl_q.valid;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;

  assign StallF = lw_stall | MemBusyM;
  assign StallD = lw_stall | MemBusyM;
  assign FlushD = flush;
endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed + randomized bench for decode_execute_stage against a whole-slot reference model.
module tb_decode_execute_stage;
  logic        clk = 0, rst = 0, flush = 0, MemBusyM = 0;
  logic [4:0]  Rs1D = 0, Rs2D = 0, RdD = 0;
  logic [31:0] RD1D = 0, RD2D = 0, ImmExtD = 0, PCD = 0, PCPlus4D = 0;
  logic        RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0, ALUSrcD = 0;
  logic [1:0]  ResultSrcD = 0;
  logic [3:0]  ALUControlD = 0;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, StallF, StallD, FlushD;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;

  int checks = 0, failures = 0;

  // Whole E slot as one vector: valid, controls, addresses, data.
  typedef struct packed {
    logic v, rw, mw, j, b, as;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [4:0] r1, r2, rd;
    logic [31:0] d1, d2, imm, pc, pc4;
  } slot_t;
  slot_t m;

  decode_execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .MemBusyM(MemBusyM),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .ValidE(ValidE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
  );

  always #5 clk = ~clk;

  function automatic slot_t dut_e();
    return {ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
            Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E};
  endfunction

  function automatic slot_t d_slot();
    return {1'b1, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
            Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D};
  endfunction

  // A load sitting in E writing a real register that D wants to read.
  function automatic logic exp_stall();
    logic hazard;
    hazard = m.v && m.rs == 2'b01 && m.rd != 0 && (m.rd == Rs1D || m.rd == Rs2D);
    return hazard || MemBusyM;
  endfunction

  task automatic set_d(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [1:0] rsrc);
    Rs1D = r1; Rs2D = r2; RdD = rd; ResultSrcD = rsrc;
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
    PCPlus4D = PCD + 4;
    RegWriteD = 1'b1; MemWriteD = $urandom_range(0, 1); JumpD = $urandom_range(0, 1);
    BranchD = $urandom_range(0, 1); ALUSrcD = $urandom_range(0, 1);
    ALUControlD = 4'($urandom_range(0, 15));
    #1;
  endtask

  // Advance one edge, update the model by action priority, settle past the edge.
  task automatic step();
    logic st;
    st = exp_stall() && !MemBusyM;
    @(posedge clk);
    if (rst) m = '0;
    else if (MemBusyM) m = m;
    else if (flush || st) m = '0;
    else m = d_slot();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; set_d(5'd1, 5'd2, 5'd3, 2'b00);
    step(); rst = 0; #1;
    checks++;
    if (dut_e() !== slot_t'(0)) begin failures++; $display("FAIL reset_slot got=%h want=0", dut_e()); end
    checks++;
    if (StallD !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", StallD); end
  endtask

  task automatic test_normal_load();
    set_d(5'd3, 5'd4, 5'd5, 2'b00); RD1D = 32'h11; #1;
    checks++;
    if (StallF !== 1'b0) begin failures++; $display("FAIL normal_nostall got=%b want=0", StallF); end
    step();
    checks++;
    if (dut_e() !== m || ValidE !== 1'b1 || RD1E !== 32'h11 || RdE !== 5'd5)
      begin failures++; $display("FAIL normal_load got=%h want=%h", dut_e(), m); end
  endtask

  task automatic test_load_use();
    set_d(5'd1, 5'd2, 5'd7, 2'b01); step();
    set_d(5'd7, 5'd7, 5'd9, 2'b00);
    checks++;
    if (StallF !== 1'b1 || StallD !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b%b want=11", StallF, StallD); end
    step();
    checks++;
    if (ValidE !== 1'b0 || RdE !== 5'd0 || dut_e() !== m)
      begin failures++; $display("FAIL lu_bubble got=%h want=%h", dut_e(), m); end
    checks++;
    if (StallD !== 1'b0) begin failures++; $display("FAIL lu_single_stall got=%b want=0", StallD); end
    step();
    checks++;
    if (ValidE !== 1'b1 || Rs1E !== 5'd7 || RdE !== 5'd9 || dut_e() !== m)
      begin failures++; $display("FAIL lu_dependent got=%h want=%h", dut_e(), m); end
  endtask

  task automatic test_load_x0();
    set_d(5'd1, 5'd2, 5'd0, 2'b01); step();
    set_d(5'd0, 5'd6, 5'd8, 2'b00);
    checks++;
    if (StallD !== 1'b0) begin failures++; $display("FAIL x0_nostall got=%b want=0", StallD); end
    step();
    checks++;
    if (ValidE !== 1'b1 || dut_e() !== m) begin failures++; $display("FAIL x0_load got=%h want=%h", dut_e(), m); end
  endtask

  task automatic test_flush();
    set_d(5'd10, 5'd11, 5'd12, 2'b10); flush = 1; MemWriteD = 1; #1;
    checks++;
    if (FlushD !== 1'b1) begin failures++; $display("FAIL flushd got=%b want=1", FlushD); end
    step(); flush = 0; #1;
    checks++;
    if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || dut_e() !== m)
      begin failures++; $display("FAIL flush_bubble got=%h want=%h", dut_e(), m); end
  endtask

  task automatic test_busy_flush();
    slot_t snap;
    set_d(5'd13, 5'd14, 5'd15, 2'b00); step();
    snap = m;
    MemBusyM = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      set_d(5'($urandom_range(0, 31)), 5'd2, 5'd3, 2'b00);
      checks++;
      if (StallF !== 1'b1) begin failures++; $display("FAIL busy_stall%0d got=%b want=1", i, StallF); end
      step();
      checks++;
      if (dut_e() !== snap) begin failures++; $display("FAIL busy_hold%0d got=%h want=%h", i, dut_e(), snap); end
    end
    MemBusyM = 0; #1; step(); flush = 0; #1;
    checks++;
    if (ValidE !== 1'b0 || dut_e() !== slot_t'(0)) begin failures++; $display("FAIL busy_then_flush got=%h want=0", dut_e()); end
  endtask

  task automatic test_reset_mid_stall();
    set_d(5'd1, 5'd2, 5'd7, 2'b01); step();
    set_d(5'd7, 5'd3, 5'd4, 2'b00);
    checks++;
    if (StallD !== 1'b1) begin failures++; $display("FAIL rms_pre got=%b want=1", StallD); end
    rst = 1; step(); rst = 0; #1;
    checks++;
    if (ValidE !== 1'b0 || StallD !== 1'b0 || dut_e() !== slot_t'(0))
      begin failures++; $display("FAIL rms_clear got=%h stall=%b want=0", dut_e(), StallD); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_d(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 2)));
      RegWriteD = $urandom_range(0, 1);
      MemBusyM = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 15);
      rst      = ($urandom_range(0, 99) < 3);
      #1;
      checks++;
      if (StallF !== exp_stall() || StallD !== exp_stall() || FlushD !== flush)
        begin failures++; $display("FAIL rnd_comb%0d got=%b%b%b want=%b%b%b", n, StallF, StallD, FlushD, exp_stall(), exp_stall(), flush); end
      step();
      checks++;
      if (dut_e() !== m) begin failures++; $display("FAIL rnd_slot%0d got=%h want=%h", n, dut_e(), m); end
    end
    rst = 0; MemBusyM = 0; flush = 0;
  endtask

  initial begin
    m = '0;
    #2;
    test_reset();
    test_normal_load();
    test_load_use();
    test_load_x0();
    test_flush();
    test_busy_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_execute_stage.md
DECODE_EXECUTE_STAGE -- requirements
Module: decode_execute_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port flush  input  1  branch/jump taken in E; kill D->E transfer.
REQ-005 SHALL have port MemBusyM  input  1  data memory not ready; freeze E register.
REQ-006 SHALL have port Rs1D, Rs2D, RdD  input  5 each  decode register addresses.
REQ-007 SHALL have port RD1D, RD2D, ImmExtD, PCD, PCPlus4D  input  XLEN each  decode operands.
REQ-008 SHALL have port RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  decode controls.
REQ-009 SHALL have port ResultSrcD  input  2  00 ALU, 01 load, 10 PC+4.
REQ-010 SHALL have port ALUControlD  input  4  ALU operation.
REQ-011 SHALL have E-suffixed outputs mirroring REQ-006..REQ-010 (Rs1E, Rs2E, RdE, RD1E, ..., ALUControlE), same widths.
REQ-012 SHALL have port ValidE  output  1  E slot holds a real instruction.
REQ-013 SHALL have ports StallF, StallD  output  1 each  hold PC and F/D register.
REQ-014 SHALL have port FlushD  output  1  clear F/D register.

Function
REQ-015 SHALL compute lwStall = ValidE & (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D), combinationally.
REQ-016 SHALL drive StallF = StallD = lwStall | MemBusyM.
REQ-017 SHALL drive FlushD = flush.
REQ-018 SHALL, on each clk edge, select exactly one action by priority: rst > MemBusyM hold > flush bubble > lwStall bubble > load.
REQ-019 Hold: all E registers SHALL keep their values.
REQ-020 Bubble: ValidE, RegWriteE, MemWriteE, JumpE, BranchE SHALL be 0; Rs1E, Rs2E, RdE SHALL be 0; ResultSrcE, ALUControlE, ALUSrcE SHALL be 0; data fields don't-care, implemented as 0.
REQ-021 Load: every E register SHALL capture its D input, ValidE=1.
REQ-022 Latency SHALL be exactly one cycle from D inputs to E outputs when loading.
REQ-023 MemBusyM and flush together: hold SHALL win; flush SHALL be re-asserted by the producer while busy (block does not latch flush).
REQ-024 lwStall with RdE==0 SHALL NOT stall.
REQ-025 Zeroed Rs1E/Rs2E/RdE in a bubble SHALL guarantee no downstream forwarding match.
REQ-026 A load in E matching Rs1D and Rs2D simultaneously SHALL produce a single one-cycle stall.
REQ-027 Outputs SHALL be purely registered except StallF, StallD, FlushD.

Reset
REQ-028 On rst=1 at a clk edge, all E registers SHALL take bubble values (REQ-020) and ValidE=0.
REQ-029 During rst, StallF/StallD SHALL evaluate from post-reset state (0 one cycle after reset); FlushD follows flush.
REQ-030 Reset mid-stall SHALL clear the stall on the following cycle.

Structure
REQ-031 SHALL place ResultSrc encodings (RES_ALU, RES_LOAD, RES_PC4), ALUControl width, and a packed E control-bundle typedef in shared package pipeline_pkg.
REQ-032 SHALL contain one sub-module, load_use_detect, implementing REQ-015 combinationally.
REQ-033 SHALL not register StallF/StallD internally.

Verification
REQ-034 Normal load: D fields (Rs1D=3, Rs2D=4, RdD=5, RD1D=0x11, RegWriteD=1) -> same values on E next cycle, ValidE=1, no stall.
REQ-035 Load-use: E holds load RdE=7, Rs1D=7 -> StallF=StallD=1 one cycle, next E is bubble (ValidE=0, RdE=0), following cycle loads dependent instruction.
REQ-036 Load into x0: RdE=0, ResultSrcE=01, Rs1D=0 -> no stall, normal load.
REQ-037 flush=1 with valid D inputs -> FlushD=1, next E is bubble, RegWriteE=0, MemWriteE=0.
REQ-038 MemBusyM=1 for 3 cycles with flush=1 -> E outputs unchanged all 3 cycles, StallF=1; after busy drops with flush=1 -> bubble.
REQ-039 rst=1 during lwStall -> next cycle ValidE=0, StallD=0, all E controls 0.
